// File: rtl/serial_tx_negclk_pkg.sv
// Shared link definitions for the negative-edge serial transmitter and its future receiver.
// Optional even-parity bit after each frame is enabled by defining SERIAL_TX_PARITY_EN.
package serial_tx_negclk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    localparam bit MSB_FIRST_DEFAULT = 1'b1;

endpackage

// File: rtl/shift_reg_negclk_piso.sv
// WIDTH-bit falling-edge parallel-load/serial-shift register with async active-low clear.
// MSB_FIRST selects which end of the register feeds the serial tap.
module shift_reg_negclk_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_tap
);

    logic [WIDTH-1:0] r_data;

    // Load has priority so a back-to-back word replaces the finished frame on the same edge.
    always_ff @(negedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_din;
        end else if (i_shift) begin
            if (MSB_FIRST) begin
                r_data <= {r_data[WIDTH-2:0], 1'b0};
            end else begin
                r_data <= {1'b0, r_data[WIDTH-1:1]};
            end
        end
    end

    assign o_tap = MSB_FIRST ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/serial_tx_negclk.sv
// Parallel-in/serial-out transmitter clocked on the falling edge of Clk with Load/Ready handshake.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after each data word.
module serial_tx_negclk
    import serial_tx_negclk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    output logic             Ready,
    output logic             Sout,
    output logic             SoutValid,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    tx_state_t     r_state;
    tx_state_t     w_next;
    logic [CW-1:0] r_count;
    logic          r_done;
    logic          w_accept;
    logic          w_last_bit;
    logic          w_frame_end;
    logic          w_tap;
`ifdef SERIAL_TX_PARITY_EN
    logic          r_parity;
`endif

    assign w_last_bit = (r_count == LAST);
    assign w_accept   = Load & Ready;
    assign Done       = r_done;

    always_ff @(negedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Ready opens in the final period of a frame so a waiting word follows with no gap.
    always_comb begin
        w_next      = r_state;
        Ready       = 1'b0;
        SoutValid   = 1'b0;
        Sout        = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                Ready = 1'b1;
                if (Load) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                SoutValid = 1'b1;
                Sout      = w_tap;
`ifdef SERIAL_TX_PARITY_EN
                if (w_last_bit) begin
                    w_next = PARITY;
                end
`else
                Ready = w_last_bit;
                if (w_last_bit) begin
                    w_frame_end = 1'b1;
                    w_next      = Load ? SHIFT : IDLE;
                end
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                SoutValid   = 1'b1;
                Sout        = r_parity;
                Ready       = 1'b1;
                w_frame_end = 1'b1;
                w_next      = Load ? SHIFT : IDLE;
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(negedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_accept) begin
                r_count <= '0;
            end else if (r_state == SHIFT && !w_last_bit) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(negedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^Din;
        end
    end
`endif

    shift_reg_negclk_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .Clk     (Clk),
        .Clr     (Clr),
        .i_load  (w_accept),
        .i_shift (r_state == SHIFT),
        .i_din   (Din),
        .o_tap   (w_tap)
    );

endmodule

// File: tb/tb_serial_tx_negclk.sv
// Bench for serial_tx_negclk: one MSB-first and one LSB-first instance share stimulus and are
// compared every period against a frame-position reference model.
module tb_serial_tx_negclk;

    localparam int WIDTH = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             Clk;
    logic             Clr;
    logic             Load;
    logic [WIDTH-1:0] Din;
    logic             rdyM, soM, svM, dnM;
    logic             rdyL, soL, svL, dnL;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mWord;
    int               mPos;
    bit               mDone;

    serial_tx_negclk #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
        .Clk(Clk), .Clr(Clr), .Din(Din), .Load(Load),
        .Ready(rdyM), .Sout(soM), .SoutValid(svM), .Done(dnM)
    );

    serial_tx_negclk #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
        .Clk(Clk), .Clr(Clr), .Din(Din), .Load(Load),
        .Ready(rdyL), .Sout(soL), .SoutValid(svL), .Done(dnL)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    function automatic bit modelBit(bit msb);
        if (mPos < 0) return 1'b0;
        if (mPos >= WIDTH) return ^mWord;
        return msb ? mWord[WIDTH-1-mPos] : mWord[mPos];
    endfunction

    function automatic logic [7:0] expVec();
        bit rdy;
        bit sv;
        rdy = (mPos < 0) || (mPos == FRAME - 1);
        sv  = (mPos >= 0);
        return {rdy, sv, modelBit(1'b1), mDone, rdy, sv, modelBit(1'b0), mDone};
    endfunction

    function automatic logic [7:0] obsVec();
        return {rdyM, svM, soM, dnM, rdyL, svL, soL, dnL};
    endfunction

    task automatic modelReset();
        mPos  = -1;
        mDone = 1'b0;
        mWord = '0;
    endtask

    // Advance the model with the inputs present at the coming falling edge, then settle past it.
    task automatic tick();
        bit rdy;
        rdy = (mPos < 0) || (mPos == FRAME - 1);
        if (Clr) begin
            mDone = (mPos == FRAME - 1);
            if (Load && rdy) begin
                mWord = Din;
                mPos  = 0;
            end else if (mPos >= 0 && mPos < FRAME - 1) begin
                mPos++;
            end else begin
                mPos = -1;
            end
        end
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Clr  = 1'b1;
        Load = 1'b0;
        Din  = '0;
        modelReset();
        #2 Clr = 1'b0;
        #2;
        checks++;
        if (obsVec() !== 8'b1000_1000) begin
            errors++;
            $display("[TB] FAIL reset_async got %b want %b", obsVec(), 8'b1000_1000);
        end
        Load = 1'b1;
        Din  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obsVec() !== 8'b1000_1000) begin
                errors++;
                $display("[TB] FAIL reset_held cycle %0d got %b want %b", i, obsVec(), 8'b1000_1000);
            end
        end
        Load = 1'b0;
        Clr  = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] words [2];
        logic [WIDTH-1:0] wantM [2];
        logic [WIDTH-1:0] wantL [2];
        logic [WIDTH-1:0] capM, capL;
        int dones;
        words = '{8'hA5, 8'h01};
        wantM = '{8'hA5, 8'h01};
        wantL = '{8'hA5, 8'h80};
        for (int w = 0; w < 2; w++) begin
            Load = 1'b1;
            Din  = words[w];
            tick();
            Load  = 1'b0;
            capM  = '0;
            capL  = '0;
            dones = 0;
            for (int i = 0; i <= FRAME + 1; i++) begin
                checks++;
                if (obsVec() !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL single w%0d cycle %0d got %b want %b", w, i, obsVec(), expVec());
                end
                if (i < WIDTH) begin
                    capM[WIDTH-1-i] = soM;
                    capL[WIDTH-1-i] = soL;
                end
                if (dnM) dones++;
                Din = WIDTH'($urandom());
                tick();
            end
            checks++;
            if (capM !== wantM[w] || capL !== wantL[w]) begin
                errors++;
                $display("[TB] FAIL single_bits w%0d got %h/%h want %h/%h", w, capM, capL, wantM[w], wantL[w]);
            end
            checks++;
            if (dones != 1) begin
                errors++;
                $display("[TB] FAIL single_done w%0d got %0d want 1", w, dones);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit sent [$];
        logic [2*WIDTH-1:0] got;
        int dones, drops;
        Load = 1'b1;
        Din  = 8'hA5;
        tick();
        Din   = 8'h3C;
        dones = 0;
        drops = 0;
        for (int i = 0; i <= 2 * FRAME + 1; i++) begin
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL b2b cycle %0d got %b want %b", i, obsVec(), expVec());
            end
            if (mPos >= 0 && mPos < WIDTH) sent.push_back(soM);
            if (dnM) dones++;
            if (i < 2 * FRAME && !svM) drops++;
            if (i == FRAME) Load = 1'b0;
            tick();
        end
        got = '0;
        for (int i = 0; i < sent.size() && i < 2 * WIDTH; i++) got[2*WIDTH-1-i] = sent[i];
        checks++;
        if (got !== 16'hA53C || sent.size() != 2 * WIDTH) begin
            errors++;
            $display("[TB] FAIL b2b_bits got %h (%0d bits) want a53c", got, sent.size());
        end
        checks++;
        if (dones != 2 || drops != 0) begin
            errors++;
            $display("[TB] FAIL b2b_flow got done=%0d drops=%0d want done=2 drops=0", dones, drops);
        end
    endtask

    task automatic test_ignore_load();
        logic [WIDTH-1:0] cap;
        Load = 1'b1;
        Din  = 8'h00;
        tick();
        Load = 1'b0;
        cap  = '1;
        for (int i = 0; i <= 2 * FRAME + 1; i++) begin
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL ignore cycle %0d got %b want %b", i, obsVec(), expVec());
            end
            if (i < WIDTH) cap[WIDTH-1-i] = soM;
            if (i >= 2 && i <= 5) begin
                checks++;
                if (rdyM !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ignore_ready cycle %0d got %b want 0", i, rdyM);
                end
            end
            if (i == FRAME) begin
                checks++;
                if (svM !== 1'b1 || soM !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL ignore_next got sv=%b so=%b want sv=1 so=1", svM, soM);
                end
                Load = 1'b0;
            end
            if (i == 2) begin
                Load = 1'b1;
                Din  = 8'hFF;
            end
            tick();
        end
        checks++;
        if (cap !== 8'h00) begin
            errors++;
            $display("[TB] FAIL ignore_bits got %h want 00", cap);
        end
    endtask

    task automatic test_clr_midframe();
        logic [WIDTH-1:0] cap;
        int dones;
        Load = 1'b1;
        Din  = 8'hA5;
        tick();
        Load  = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dnM) dones++;
        end
        Clr = 1'b0;
        #2;
        modelReset();
        checks++;
        if (obsVec() !== 8'b1000_1000) begin
            errors++;
            $display("[TB] FAIL clr_abort got %b want %b", obsVec(), 8'b1000_1000);
        end
        tick();
        checks++;
        if (obsVec() !== 8'b1000_1000) begin
            errors++;
            $display("[TB] FAIL clr_low got %b want %b", obsVec(), 8'b1000_1000);
        end
        Clr  = 1'b1;
        Load = 1'b1;
        Din  = 8'h5A;
        tick();
        Load = 1'b0;
        cap  = '0;
        for (int i = 0; i <= FRAME + 1; i++) begin
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL clr_next cycle %0d got %b want %b", i, obsVec(), expVec());
            end
            if (i < WIDTH) cap[WIDTH-1-i] = soM;
            if (dnM) dones++;
            tick();
        end
        checks++;
        if (cap !== 8'h5A || dones != 1) begin
            errors++;
            $display("[TB] FAIL clr_recover got %h done=%0d want 5a done=1", cap, dones);
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] words [2];
        bit               want  [2];
        words = '{8'hA5, 8'h07};
        want  = '{1'b0, 1'b1};
        for (int w = 0; w < 2; w++) begin
            Load = 1'b1;
            Din  = words[w];
            tick();
            Load = 1'b0;
            for (int i = 0; i <= FRAME + 1; i++) begin
                checks++;
                if (obsVec() !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL parity w%0d cycle %0d got %b want %b", w, i, obsVec(), expVec());
                end
                if (i == WIDTH) begin
                    checks++;
                    if (soM !== want[w] || soL !== want[w] || dnM !== 1'b0 || rdyM !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL parity_bit w%0d got so=%b/%b done=%b rdy=%b want so=%b done=0 rdy=1",
                                 w, soM, soL, dnM, rdyM, want[w]);
                    end
                end
                if (i == FRAME) begin
                    checks++;
                    if (dnM !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL parity_done w%0d got %b want 1", w, dnM);
                    end
                end
                tick();
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Load = 1'($urandom_range(0, 1));
            Din  = WIDTH'($urandom());
            if ($urandom_range(0, 63) == 0) begin
                Clr = 1'b0;
                #2;
                modelReset();
                checks++;
                if (obsVec() !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL random_clr cycle %0d got %b want %b", i, obsVec(), expVec());
                end
                Clr = 1'b1;
            end
            tick();
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got %b want %b", i, obsVec(), expVec());
            end
        end
        Load = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_load();
        test_clr_midframe();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
